// File: rtl/gene_pair_aligner.sv
// Merges two key-sorted parent gene streams into aligned gene pairs for the crossover stage.
// Optional key-order checking is compiled in with `define ALIGN_ORDER_CHECK_EN.
module gene_pair_aligner #(
   parameter int GENE_SZ = 64,
   parameter int ATTR_SZ = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ATTR_SZ-1:0]     parent1_fitness,
   input  logic [ATTR_SZ-1:0]     parent2_fitness,
   input  logic [6*ATTR_SZ-1:0]   mutation_probs,
   input  logic [ATTR_SZ-1:0]     child_genome_id,
   input  logic                   p1_valid,
   input  logic [GENE_SZ-1:0]     p1_gene,
   input  logic                   p1_last,
   output logic                   p1_ready,
   input  logic                   p2_valid,
   input  logic [GENE_SZ-1:0]     p2_gene,
   input  logic                   p2_last,
   output logic                   p2_ready,
   output logic [GENE_SZ-1:0]     data_out1,
   output logic [GENE_SZ-1:0]     data_out2,
   output logic                   setup_out,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            pair_count,
   output logic                   order_err,
   output logic [1:0]             dbg_state
);

   localparam int KEY_HI = 7*ATTR_SZ - 1;
   localparam int KEY_LO = 5*ATTR_SZ;
   localparam int KEY_W  = KEY_HI - KEY_LO + 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_MERGE, S_DONE} state_t;

   state_t                 state;
   logic [ATTR_SZ-1:0]     fit1_q, fit2_q, id_q;
   logic [6*ATTR_SZ-1:0]   probs_q;
   logic                   ex1, ex2;
   logic [KEY_W-1:0]       k1, k2;
   logic                   fit1_wins;
   logic                   pop1, pop2;
   logic                   discard, viol;
   logic                   emit;
   logic [GENE_SZ-1:0]     e1, e2;

   assign k1        = p1_gene[KEY_HI:KEY_LO];
   assign k2        = p2_gene[KEY_HI:KEY_LO];
   assign fit1_wins = (fit1_q >= fit2_q);
   assign dbg_state = state;

   // Handshake: a gene transfers on a rising edge where valid & ready are both high;
   // ready only rises for a valid gene, so ready alone is the pop strobe.
   always_comb begin
      pop1 = 1'b0;
      pop2 = 1'b0;
      if (state == S_MERGE) begin
         if (discard) begin
            pop1 = p1_valid & ~ex1;
            pop2 = p2_valid & ~ex2;
         end else if (!ex1 && !ex2) begin
            if (p1_valid && p2_valid) begin
               if (k1 == k2) begin
                  pop1 = 1'b1;
                  pop2 = 1'b1;
               end else if (k1 < k2) begin
                  pop1 = 1'b1;
               end else begin
                  pop2 = 1'b1;
               end
            end
         end else if (!ex1) begin
            pop1 = p1_valid;
         end else if (!ex2) begin
            pop2 = p2_valid;
         end
      end
   end

   assign p1_ready = pop1;
   assign p2_ready = pop2;

   // Unmatched genes survive only when they come from the fitter parent.
   always_comb begin
      emit = 1'b0;
      e1   = '0;
      e2   = '0;
      if (!discard && !viol) begin
         if (pop1 && pop2) begin
            emit = 1'b1;
            e1   = p1_gene;
            e2   = p2_gene;
         end else if (pop1 && fit1_wins) begin
            emit = 1'b1;
            e1   = p1_gene;
            e2   = p1_gene;
         end else if (pop2 && !fit1_wins) begin
            emit = 1'b1;
            e1   = p2_gene;
            e2   = p2_gene;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         fit1_q     <= '0;
         fit2_q     <= '0;
         id_q       <= '0;
         probs_q    <= '0;
         ex1        <= 1'b0;
         ex2        <= 1'b0;
         data_out1  <= '0;
         data_out2  <= '0;
         setup_out  <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pair_count <= '0;
      end else begin
         setup_out <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         data_out1 <= '0;
         data_out2 <= '0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_SETUP;
                  busy       <= 1'b1;
                  fit1_q     <= parent1_fitness;
                  fit2_q     <= parent2_fitness;
                  probs_q    <= mutation_probs;
                  id_q       <= child_genome_id;
                  ex1        <= 1'b0;
                  ex2        <= 1'b0;
                  pair_count <= '0;
                  setup_out  <= 1'b1;
                  data_out1  <= {parent1_fitness, parent2_fitness, mutation_probs};
                  data_out2  <= {{(GENE_SZ-ATTR_SZ){1'b0}}, child_genome_id};
               end
            end
            S_SETUP: state <= S_MERGE;
            S_MERGE: begin
               if (ex1 && ex2) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  if (pop1 && p1_last) ex1 <= 1'b1;
                  if (pop2 && p2_last) ex2 <= 1'b1;
                  if (emit) begin
                     out_valid <= 1'b1;
                     data_out1 <= e1;
                     data_out2 <= e2;
                     if (pair_count != 16'hFFFF) pair_count <= pair_count + 16'd1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ALIGN_ORDER_CHECK_EN
   logic [KEY_W-1:0] prev1, prev2;
   logic             have1, have2, discard_q;

   assign discard = discard_q;
   assign viol    = (pop1 && have1 && (k1 <= prev1)) || (pop2 && have2 && (k2 <= prev2));

   // After a violation the rest of both streams is drained without emitting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev1     <= '0;
         prev2     <= '0;
         have1     <= 1'b0;
         have2     <= 1'b0;
         discard_q <= 1'b0;
         order_err <= 1'b0;
      end else if (state == S_IDLE && start) begin
         prev1     <= '0;
         prev2     <= '0;
         have1     <= 1'b0;
         have2     <= 1'b0;
         discard_q <= 1'b0;
         order_err <= 1'b0;
      end else if (state == S_MERGE) begin
         if (pop1) begin
            prev1 <= k1;
            have1 <= 1'b1;
         end
         if (pop2) begin
            prev2 <= k2;
            have2 <= 1'b1;
         end
         if (viol) begin
            order_err <= 1'b1;
            discard_q <= 1'b1;
         end
      end
   end
`else
   assign discard   = 1'b0;
   assign viol      = 1'b0;
   assign order_err = 1'b0;
`endif

endmodule
